left_shift_seq_32: RTL

Multi-cycle 32-bit logical left shifter for the ALU's SLL path: the shift-left counterpart of the combinational signed right shifter. It applies the five binary shift stages (1, 2, 4, 8, 16) one per clock cycle under a small FSM. A start/busy/done handshake lets the ALU controller launch an operation and collect the zero-filled result after a fixed latency.

---
 rtl/left_shift_seq_32_if.sv | 20 ++
 rtl/left_shift_seq_32.sv | 97 +++++++++
 2 files changed

// File: rtl/left_shift_seq_32_if.sv
// Handshake and data bundle between the ALU controller and the sequential
// left shifter; the controller side is master, the shifter side is slave.
interface left_shift_seq_32_if;
   logic        ctrl_start;
   logic [4:0]  ctrl_shiftamt;
   logic [31:0] data_in;
   logic [31:0] data_out;
   logic        busy;
   logic        done;

   modport master (
      output ctrl_start, ctrl_shiftamt, data_in,
      input  data_out, busy, done
   );

   modport slave (
      input  ctrl_start, ctrl_shiftamt, data_in,
      output data_out, busy, done
   );
endinterface

// File: rtl/left_shift_seq_32.sv
// Multi-cycle 32-bit logical left shifter: one binary stage (1,2,4,8,16) per
// clock, fixed 5-cycle latency, start/busy/done handshake.
module left_shift_seq_32 (
   input  logic                 clock,
   input  logic                 reset,
   left_shift_seq_32_if.slave   bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] work_q;
   logic [4:0]  amt_q;
   logic [2:0]  k_q;
   logic [31:0] result_q;
   logic [31:0] stage_val;
   logic        accept;
   logic        busy_c;
   logic        done_c;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values, independent of block ordering.
   always_ff @(posedge clock) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // NOTE: every output of this block gets a default first, so no path
   // leaves a signal unassigned and no latch is inferred.
   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      busy_c  = 1'b0;
      done_c  = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.ctrl_start) begin
               accept  = 1'b1;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            busy_c = 1'b1;
            if (k_q == 3'd4) state_d = DONE;
         end
         DONE: begin
            done_c = 1'b1;
            if (bus.ctrl_start) begin
               accept  = 1'b1;
               state_d = SHIFT;
            end else begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // One stage per cycle: stage k shifts by 2^k when amt[k] is set.
   always_comb begin
      stage_val = work_q;
      case (k_q)
         3'd0: if (amt_q[0]) stage_val = {work_q[30:0], 1'b0};
         3'd1: if (amt_q[1]) stage_val = {work_q[29:0], 2'b0};
         3'd2: if (amt_q[2]) stage_val = {work_q[27:0], 4'b0};
         3'd3: if (amt_q[3]) stage_val = {work_q[23:0], 8'b0};
         3'd4: if (amt_q[4]) stage_val = {work_q[15:0], 16'b0};
         default: stage_val = work_q;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         work_q   <= '0;
         amt_q    <= '0;
         k_q      <= '0;
         result_q <= '0;
      end else if (accept) begin
         work_q <= bus.data_in;
         amt_q  <= bus.ctrl_shiftamt;
         k_q    <= '0;
      end else if (state_q == SHIFT) begin
         work_q <= stage_val;
         k_q    <= k_q + 3'd1;
         if (k_q == 3'd4) result_q <= stage_val;
      end
   end

   assign bus.data_out = result_q;
   assign bus.busy     = busy_c;
   assign bus.done     = done_c;

endmodule
